// File: rtl/serial_addsub.sv
// serial_addsub -- bit-serial adder/subtractor with accumulate mode.
//
// Operands are captured on a start strobe and pushed through one full adder,
// least significant bit first, one bit per clock. The result is published
// to sum/ovf in a single step when the last bit has been processed.
//
// Ports
//   clk    in   1         system clock, rising edge
//   rst    in   1         synchronous active-high reset, highest priority
//   start  in   1         request an operation (sampled only while idle)
//   sub    in   1         0: X+B, 1: X-B computed as X+~B+1
//   accum  in   1         0: X=a, 1: X=sum[WIDTH-1:0] (running total)
//   a      in   WIDTH     operand A
//   b      in   WIDTH     operand B
//   busy   out  1         high while an operation is in progress
//   done   out  1         one-cycle pulse when sum/ovf have been updated
//   sum    out  WIDTH+1   registered result, [WIDTH] is the final carry-out
//   ovf    out  1         two's-complement overflow of the last operation
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             accum,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_x;      // X operand, shifted right each bit
  logic [WIDTH-1:0] r_y;      // Y operand (b or ~b), shifted right each bit
  logic [WIDTH-1:0] r_s;      // partial sum bits, entering at the MSB
  logic             r_carry;
  logic [WIDTH:0]   r_sum;
  logic             r_ovf;
  logic             r_done;

  logic w_bit_s;
  logic w_bit_c;
  logic w_last;
  logic w_accept;

  // Single full adder on the current LSBs.
  assign w_bit_s = r_x[0] ^ r_y[0] ^ r_carry;
  assign w_bit_c = (r_x[0] & r_y[0]) | (r_x[0] & r_carry) | (r_y[0] & r_carry);
  assign w_last  = (r_state == S_CALC) && (r_cnt == LAST);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_CALC;
          w_accept     = 1'b1;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // In accumulate mode the old carry-out is dropped: only the low
        // WIDTH bits of the previous result feed back.
        r_x     <= accum ? r_sum[WIDTH-1:0] : a;
        r_y     <= sub ? ~b : b;
        r_carry <= sub;
        r_cnt   <= '0;
      end else if (r_state == S_CALC) begin
        r_x     <= r_x >> 1;
        r_y     <= r_y >> 1;
        r_s     <= {w_bit_s, r_s[WIDTH-1:1]};
        r_carry <= w_bit_c;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          // r_carry here is the carry into the MSB; w_bit_c is the carry out.
          r_sum  <= {w_bit_c, w_bit_s, r_s[WIDTH-1:1]};
          r_ovf  <= r_carry ^ w_bit_c;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = (r_state == S_CALC);
  assign done = r_done;
  assign sum  = r_sum;
  assign ovf  = r_ovf;

endmodule
